// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter that lets two serial requesters share one N-bit
// shift register and hands each finished word out on a valid/ready port.
module serial_frame_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req,
  input  logic [1:0]   sdata,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_src,
  output logic         abort
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sr_q, sr_d;
  logic          last_src_q, last_src_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_src_q, out_src_d;
  logic          abort_q, abort_d;
  logic          winner;

  // On a tie the source that was not served last wins; otherwise the lone requester.
  // last_src_q doubles as the select of the source currently being shifted.
  assign winner = (req == 2'b11) ? ~last_src_q : req[1];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    last_src_d  = last_src_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    abort_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          last_src_d = winner;
          grant_d    = winner ? 2'b10 : 2'b01;
          cnt_d      = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!req[last_src_q]) begin
          // Requester let go mid-frame: discard without touching the output port.
          grant_d = 2'b00;
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          sr_d  = {sr_q[N-2:0], sdata[last_src_q]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            grant_d     = 2'b00;
            out_data_d  = sr_d;
            out_src_d   = last_src_q;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      cnt_q       <= '0;
      sr_q        <= '0;
      last_src_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      last_src_q  <= last_src_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      abort_q     <= abort_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Randomized frame-level bench for serial_frame_arbiter (N=4 and N=8 instances)
// against a transaction model of the arbitration and timing rules.
module tb_serial_frame_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, sdata, grant;
  logic       busy, out_valid, out_ready, out_src, abort;
  logic [3:0] out_data;

  logic [1:0] req8, sdata8, grant8;
  logic       busy8, out_valid8, out_ready8, out_src8, abort8;
  logic [7:0] out_data8;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int         last_src;
  logic [3:0] exp_data;
  logic       exp_src;

  always #5 clk = ~clk;

  serial_frame_arbiter #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .sdata(sdata), .grant(grant),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .abort(abort)
  );

  serial_frame_arbiter #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .sdata(sdata8), .grant(grant8),
    .busy(busy8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_src(out_src8), .abort(abort8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (last_src == 0) ? 1 : 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_src"}, out_src, 0);
    check({tag, "_abort"}, abort, 0);
  endtask

  task automatic drive_bit(input int w, input logic b);
    logic o;
    o = 1'($urandom_range(0, 1));
    sdata = (w == 0) ? {o, b} : {b, o};
  endtask

  // One frame on the N=4 instance, starting from IDLE.
  task automatic do_frame(input logic [1:0] r, input logic [3:0] word,
                          input int abort_k, input int hold_d);
    int w;
    w = pick(r);
    last_src = w;
    req = r;
    out_ready = 1'b0;
    step();
    check("grant_on", grant, 32'(1 << w));
    check("busy_on", busy, 1);
    for (int k = 0; k < 4; k++) begin
      drive_bit(w, word[3-k]);
      if (k == abort_k) req = 2'b00;
      step();
      if (k == abort_k) begin
        check("abort_pulse", abort, 1);
        check("abort_grant", grant, 0);
        check("abort_valid", out_valid, 0);
        check("abort_data_kept", out_data, exp_data);
        check("abort_src_kept", out_src, exp_src);
        step();
        check("abort_clear", abort, 0);
        check("abort_idle", busy, 0);
        $display("[TB] frame req=%b src=%0d aborted at bit %0d", r, w, k);
        return;
      end
      if (k < 3) check("grant_hold", grant, 32'(1 << w));
    end
    exp_data = word;
    exp_src  = 1'(w);
    check("valid_rise", out_valid, 1);
    check("grant_fall", grant, 0);
    check("word", out_data, exp_data);
    check("src", out_src, exp_src);
    for (int i = 0; i < hold_d; i++) begin
      req = 2'($urandom_range(0, 3));
      step();
      check("hold_valid", out_valid, 1);
      check("hold_nogrant", grant, 0);
      check("hold_data", out_data, exp_data);
      check("hold_src", out_src, exp_src);
    end
    out_ready = 1'b1;
    step();
    check("accept_valid", out_valid, 0);
    check("accept_idle", busy, 0);
    req = 2'b00;
    out_ready = 1'b0;
    $display("[TB] frame req=%b src=%0d word=%h hold=%0d", r, w, word, hold_d);
  endtask

  task automatic do_frame8(input logic [7:0] word);
    req8 = 2'b10;
    out_ready8 = 1'b0;
    step();
    check("n8_grant", grant8, 2'b10);
    for (int k = 0; k < 8; k++) begin
      sdata8 = {word[7-k], 1'($urandom_range(0, 1))};
      step();
    end
    check("n8_valid", out_valid8, 1);
    check("n8_word", out_data8, word);
    check("n8_src", out_src8, 1);
    out_ready8 = 1'b1;
    step();
    check("n8_accept", out_valid8, 0);
    req8 = 2'b00;
    out_ready8 = 1'b0;
    $display("[TB] n8 frame src=1 word=%h", word);
  endtask

  initial begin
    int   rises, last_rise, cyc, w;
    logic done;
    logic [1:0] prev_g;

    reset = 1'b1; req = 0; sdata = 0; out_ready = 0;
    req8 = 0; sdata8 = 0; out_ready8 = 0;
    last_src = 1; exp_data = 0; exp_src = 0;
    step(); step();
    check_reset_outputs("rst");
    check("rst_n8_valid", out_valid8, 0);
    check("rst_n8_data", out_data8, 0);
    reset = 1'b0;

    do_frame(2'b01, 4'b1011, -1, 0);

    // Back-to-back ties: source 0 streams ones, source 1 streams zeros.
    req = 2'b11; out_ready = 1'b1; sdata = 2'b01;
    rises = 0; last_rise = -1; cyc = 0; done = 1'b0; prev_g = 2'b00;
    for (int c = 0; c < 80 && !done; c++) begin
      step();
      cyc++;
      if (grant != 2'b00 && prev_g == 2'b00) begin
        w = pick(2'b11);
        last_src = w;
        check("tie_grant", grant, 32'(1 << w));
        if (last_rise >= 0) check("period", cyc - last_rise, 6);
        last_rise = cyc;
        rises++;
        $display("[TB] tie grant=%b at cycle %0d", grant, cyc);
      end
      if (out_valid) begin
        exp_src  = 1'(last_src);
        exp_data = (last_src == 0) ? 4'hF : 4'h0;
        check("tie_src", out_src, exp_src);
        check("tie_word", out_data, exp_data);
        if (rises == 4) begin
          req = 2'b00;
          step();
          check("tie_end", out_valid, 0);
          done = 1'b1;
        end
      end
      prev_g = grant;
    end
    if (!done) check("tie_timeout", 0, 1);
    out_ready = 1'b0;

    do_frame(2'b11, 4'($urandom), -1, 10);
    do_frame(2'b01, 4'($urandom), 2, 0);

    // Reset mid-SHIFT after two shifted bits.
    req = 2'b01; step();
    sdata = 2'b01; step(); step();
    reset = 1'b1; step();
    req = 2'b00; reset = 1'b0;
    check_reset_outputs("rst_shift");
    last_src = 1; exp_data = 0; exp_src = 0;
    $display("[TB] reset mid-shift");

    // Reset while holding a finished word.
    req = 2'b10; step();
    for (int k = 0; k < 4; k++) begin sdata = 2'b10; step(); end
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b1; step();
    req = 2'b00; reset = 1'b0;
    check_reset_outputs("rst_hold");
    last_src = 1; exp_data = 0; exp_src = 0;
    $display("[TB] reset in hold");

    do_frame(2'b11, 4'($urandom), -1, 1);

    for (int i = 0; i < 40; i++) begin
      do_frame(2'($urandom_range(1, 3)), 4'($urandom),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
               int'($urandom_range(0, 3)));
    end

    do_frame8(8'hA5);
    for (int i = 0; i < 3; i++) do_frame8(8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
